// File: rtl/pearson_pkg.sv
// Shared types and constants for the Pearson hash message feeder.
package pearson_pkg;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } feeder_state_e;

  localparam int PEARSON_DW = 8;

  // Width needed to hold a length in 0..depth inclusive.
  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pearson_msg_feeder_if.sv
// Source byte stream and hash-core beat stream of the message feeder.
interface pearson_msg_feeder_if
  import pearson_pkg::*;
#(
  parameter int DW = PEARSON_DW
);

  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_last_i;
  logic          in_ready_o;
  logic [DW-1:0] hc_data_o;
  logic          hc_valid_o;
  logic          hc_first_o;
  logic          hc_last_o;
  logic          hc_ready_i;

  modport master (
    output in_data_i, in_valid_i, in_last_i, hc_ready_i,
    input  in_ready_o, hc_data_o, hc_valid_o, hc_first_o, hc_last_o
  );

  modport slave (
    input  in_data_i, in_valid_i, in_last_i, hc_ready_i,
    output in_ready_o, hc_data_o, hc_valid_o, hc_first_o, hc_last_o
  );

endinterface

// File: rtl/pearson_msg_buf.sv
// Message storage: register array with synchronous write and combinational read.
module pearson_msg_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately left unreset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pearson_msg_feeder.sv
// Buffers one message from a byte stream and replays it to the Pearson hash core
// one byte per accepted beat, tagged with first/last flags.
module pearson_msg_feeder
  import pearson_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = PEARSON_DW
) (
  input  logic                         clk,
  input  logic                         reset,
  pearson_msg_feeder_if.slave          bus,
  output logic [len_width(DEPTH)-1:0]  msg_len_o,
  output logic                         overflow_o,
  output logic                         busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = len_width(DEPTH);

  feeder_state_e state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] msg_len_q, msg_len_d;
  logic          overflow_q, overflow_d;

  logic          is_drain;
  logic          in_fire;
  logic          hc_fire;
  logic          last_beat;
  logic [DW-1:0] buf_rdata;

  assign is_drain  = (state_q == DRAIN);
  assign in_fire   = bus.in_valid_i & ~is_drain;
  assign hc_fire   = is_drain & bus.hc_ready_i;
  assign last_beat = is_drain & (LW'(rd_ptr_q) == (msg_len_q - LW'(1)));

  pearson_msg_buf #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .we_i    (in_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  // State, pointer, length and overflow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      msg_len_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      msg_len_q  <= msg_len_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic: a full buffer without a last flag is closed as a truncated message.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    msg_len_d  = msg_len_q;
    overflow_d = overflow_q;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == '0) begin
            overflow_d = 1'b0;
          end else begin
            overflow_d = overflow_q;
          end
          if (bus.in_last_i) begin
            msg_len_d = LW'(wr_ptr_q) + LW'(1);
            state_d   = DRAIN;
          end else if (wr_ptr_q == AW'(DEPTH - 1)) begin
            msg_len_d  = LW'(DEPTH);
            overflow_d = 1'b1;
            state_d    = DRAIN;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (hc_fire && last_beat) begin
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          state_d  = FILL;
        end else if (hc_fire) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign bus.in_ready_o = ~is_drain;
  assign bus.hc_valid_o = is_drain;
  assign bus.hc_data_o  = is_drain ? buf_rdata : '0;
  assign bus.hc_first_o = is_drain & (rd_ptr_q == '0);
  assign bus.hc_last_o  = last_beat;
  assign busy_o         = is_drain;
  assign msg_len_o      = msg_len_q;
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_pearson_msg_feeder.sv
// Randomised and directed bench for pearson_msg_feeder against a queue-based message model.
module tb_pearson_msg_feeder;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] msg_len;
  logic          overflow;
  logic          busy;

  always #5 clk = ~clk;

  pearson_msg_feeder_if #(.DW(DW)) bus ();

  pearson_msg_feeder #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .msg_len_o  (msg_len),
    .overflow_o (overflow),
    .busy_o     (busy)
  );

  // Model: bytes collected so far, and the message currently being replayed.
  byte unsigned fill_q[$];
  byte unsigned drain_q[$];
  int           idx;
  int           m_len;
  bit           m_ovf;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    drain_q.delete();
    idx   = 0;
    m_len = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    bit dr;
    dr = (drain_q.size() != 0);
    check_eq("in_ready", bus.in_ready_o, !dr);
    check_eq("hc_valid", bus.hc_valid_o, dr);
    check_eq("busy", busy, dr);
    check_eq("hc_data", bus.hc_data_o, dr ? drain_q[idx] : 8'h00);
    check_eq("hc_first", bus.hc_first_o, dr && (idx == 0));
    check_eq("hc_last", bus.hc_last_o, dr && (idx == drain_q.size() - 1));
    check_eq("msg_len", msg_len, m_len);
    check_eq("overflow", overflow, m_ovf);
  endtask

  // One clock: check outputs for the driven inputs, clock, then advance the model.
  task automatic step();
    bit           dr, in_acc, hc_acc, lst;
    byte unsigned b;
    dr     = (drain_q.size() != 0);
    in_acc = !dr && bus.in_valid_i;
    hc_acc = dr && bus.hc_ready_i;
    b      = bus.in_data_i;
    lst    = bus.in_last_i;
    check_outputs();
    @(posedge clk);
    #1;
    if (hc_acc) begin
      idx++;
      if (idx == drain_q.size()) begin
        drain_q.delete();
        idx = 0;
      end
    end
    if (in_acc) begin
      if (fill_q.size() == 0) m_ovf = 1'b0;
      fill_q.push_back(b);
      if (lst || fill_q.size() == DEPTH) begin
        m_len   = fill_q.size();
        m_ovf   = !lst;
        drain_q = fill_q;
        fill_q.delete();
        idx = 0;
      end
    end
  endtask

  task automatic drive(input bit v, input byte unsigned d, input bit l, input bit r);
    bus.in_valid_i = v;
    bus.in_data_i  = d;
    bus.in_last_i  = l;
    bus.hc_ready_i = r;
    step();
  endtask

  task automatic idle_count(input int n, output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (busy) busy_cycles++;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
    end
  endtask

  int           cnt;
  bit [6:0]     rdy_pat;
  byte unsigned msg3[3];

  initial begin
    reset          = 1'b1;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    bus.in_last_i  = 1'b0;
    bus.hc_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();

    // Three-byte message, drain with ready held high.
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    drive(1'b0, 8'h99, 1'b1, 1'b1);
    drive(1'b1, 8'h22, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 1'b1, 1'b1);
    check_eq("three_len", msg_len, 3);
    idle_count(5, cnt);
    check_eq("three_drain_cycles", cnt, 3);

    // Single-byte message.
    drive(1'b1, 8'hA5, 1'b1, 1'b1);
    check_eq("single_first", bus.hc_first_o, 1'b1);
    check_eq("single_last", bus.hc_last_o, 1'b1);
    idle_count(3, cnt);
    check_eq("single_drain_cycles", cnt, 1);

    // Backpressure pattern 1,0,0,1,1,0,1 over a four-byte message.
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), i == 4, 1'b0);
    rdy_pat = 7'b1011001;
    for (int i = 0; i < 7; i++) drive(1'b0, 8'h00, 1'b0, rdy_pat[i]);
    check_eq("bp_done_busy", busy, 1'b0);

    // Sixteen bytes without last: truncated at DEPTH.
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    check_eq("ovf_len", msg_len, DEPTH);
    check_eq("ovf_flag", overflow, 1'b1);
    idle_count(DEPTH + 2, cnt);
    check_eq("ovf_drain_cycles", cnt, DEPTH);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    check_eq("ovf_cleared", overflow, 1'b0);
    drive(1'b1, 8'h78, 1'b1, 1'b1);
    idle_count(3, cnt);

    // Reset while the beat for byte 1 of AA,BB,CC is pending.
    msg3 = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++) drive(1'b1, msg3[i], i == 2, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("pre_rst_data", bus.hc_data_o, 8'hBB);
    reset = 1'b1;
    model_reset();
    #2;
    check_eq("rst_hc_valid", bus.hc_valid_o, 1'b0);
    check_eq("rst_hc_first", bus.hc_first_o, 1'b0);
    check_eq("rst_hc_last", bus.hc_last_o, 1'b0);
    check_eq("rst_hc_data", bus.hc_data_o, 8'h00);
    check_eq("rst_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs();
    drive(1'b1, 8'h5A, 1'b1, 1'b1);
    check_eq("post_rst_first", bus.hc_first_o, 1'b1);
    check_eq("post_rst_data", bus.hc_data_o, 8'h5A);
    idle_count(2, cnt);

    // Source keeps valid high with fresh data across a whole drain.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'hC0 + i), i == 2, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'hD0 + i), 1'b0, 1'b1);
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    idle_count(10, cnt);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
